// File: rtl/writeback_stage_if.sv
// writeback_stage_if: MEM->WB bus for the writeback stage.
//   master : memory stage side, drives the in_* fields, sees in_ready and the
//            registered writeback results.
//   slave  : writeback stage side, consumes in_*, drives in_ready, wb_valid,
//            reg_write, write_reg and result.
// Lane i occupies bits [i*W +: W] of every packed multi-lane field.
interface writeback_stage_if #(
   parameter int LANES  = 1,
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic [LANES-1:0]        in_valid;
   logic                    in_ready;
   logic [LANES-1:0]        in_reg_write;
   logic [LANES-1:0]        in_mem_to_reg;
   logic [LANES*REG_AW-1:0] in_write_reg;
   logic [LANES*DATA_W-1:0] in_alu_result;
   logic [LANES*DATA_W-1:0] in_read_data;
   logic [LANES*2-1:0]      in_ld_size;
   logic [LANES-1:0]        in_ld_unsigned;
   logic [LANES*2-1:0]      in_byte_off;
   logic [LANES-1:0]        wb_valid;
   logic [LANES-1:0]        reg_write;
   logic [LANES*REG_AW-1:0] write_reg;
   logic [LANES*DATA_W-1:0] result;

   modport master (
      output in_valid, in_reg_write, in_mem_to_reg, in_write_reg, in_alu_result,
             in_read_data, in_ld_size, in_ld_unsigned, in_byte_off,
      input  in_ready, wb_valid, reg_write, write_reg, result
   );

   modport slave (
      input  in_valid, in_reg_write, in_mem_to_reg, in_write_reg, in_alu_result,
             in_read_data, in_ld_size, in_ld_unsigned, in_byte_off,
      output in_ready, wb_valid, reg_write, write_reg, result
   );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: final MEM->WB pipeline stage of the MIPS core.
//   Registers LANES memory-stage results (1 cycle), extracts/extends load
//   data, selects ALU vs load result and drives the register-file write
//   ports with $0 suppression and youngest-writer-wins conflict resolution.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   stall       : hold the stage register (in_ready = !stall)
//   flush       : invalidate the stage register (beats stall)
//   bus         : writeback_stage_if.slave, MEM inputs and WB outputs
//   retire_cnt  : 32-bit retired-lane counter, present only when the macro
//                 WB_RETIRE_CNT_EN is defined
module writeback_stage #(
   parameter int LANES  = 1,
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    stall,
   input  logic                    flush,
   writeback_stage_if.slave        bus
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [31:0]             retire_cnt
`endif
);

   logic [LANES-1:0]        vld_p1;
   logic [LANES-1:0]        reg_write_p1;
   logic [LANES-1:0]        mem_to_reg_p1;
   logic [LANES*REG_AW-1:0] write_reg_p1;
   logic [LANES*DATA_W-1:0] alu_result_p1;
   logic [LANES*DATA_W-1:0] read_data_p1;
   logic [LANES*2-1:0]      ld_size_p1;
   logic [LANES-1:0]        ld_unsigned_p1;
   logic [LANES*2-1:0]      byte_off_p1;
   logic [LANES-1:0]        conflict;

   // Byte/half/word extraction from the aligned word; half ignores off[0].
   function automatic logic [DATA_W-1:0] load_extract(
      input logic [DATA_W-1:0] data,
      input logic [1:0]        size,
      input logic              uns,
      input logic [1:0]        off
   );
      logic [DATA_W-1:0] sel;
      logic [DATA_W-1:0] val;
      case (size)
         2'b00: begin
            sel = data >> {off, 3'b000};
            val = uns ? DATA_W'(sel[7:0]) : DATA_W'($signed(sel[7:0]));
         end
         2'b01: begin
            sel = data >> {off[1], 4'b0000};
            val = uns ? DATA_W'(sel[15:0]) : DATA_W'($signed(sel[15:0]));
         end
         default: val = data;
      endcase
      return val;
   endfunction

   function automatic logic [31:0] popcount(input logic [LANES-1:0] v);
      logic [31:0] n;
      n = '0;
      for (int i = 0; i < LANES; i++) n = n + 32'(v[i]);
      return n;
   endfunction

   assign bus.in_ready = !stall;

   // ---- MEM -> WB stage register ----
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1         <= '0;
         reg_write_p1   <= '0;
         mem_to_reg_p1  <= '0;
         write_reg_p1   <= '0;
         alu_result_p1  <= '0;
         read_data_p1   <= '0;
         ld_size_p1     <= '0;
         ld_unsigned_p1 <= '0;
         byte_off_p1    <= '0;
      end else if (flush) begin
         vld_p1 <= '0;
      end else if (!stall) begin
         vld_p1         <= bus.in_valid;
         reg_write_p1   <= bus.in_reg_write;
         mem_to_reg_p1  <= bus.in_mem_to_reg;
         write_reg_p1   <= bus.in_write_reg;
         alu_result_p1  <= bus.in_alu_result;
         read_data_p1   <= bus.in_read_data;
         ld_size_p1     <= bus.in_ld_size;
         ld_unsigned_p1 <= bus.in_ld_unsigned;
         byte_off_p1    <= bus.in_byte_off;
      end
   end

`ifdef WB_RETIRE_CNT_EN
   // Counts lanes leaving the stage; flushed lanes never leave, so are not counted.
   always_ff @(posedge clk) begin
      if (reset) begin
         retire_cnt <= '0;
      end else if (!flush && !stall) begin
         retire_cnt <= retire_cnt + popcount(vld_p1);
      end
   end
`endif

   // ---- WB outputs (combinational from stage register) ----
   // An older lane loses to any younger valid lane writing the same nonzero register.
   always_comb begin
      conflict = '0;
      for (int i = 0; i < LANES; i++) begin
         for (int j = i + 1; j < LANES; j++) begin
            if (vld_p1[j] && reg_write_p1[j] &&
                write_reg_p1[j*REG_AW +: REG_AW] != '0 &&
                write_reg_p1[j*REG_AW +: REG_AW] == write_reg_p1[i*REG_AW +: REG_AW])
               conflict[i] = 1'b1;
         end
      end
   end

   always_comb begin
      bus.reg_write = '0;
      bus.result    = '0;
      for (int i = 0; i < LANES; i++) begin
         bus.reg_write[i] = vld_p1[i] && reg_write_p1[i] &&
                            (write_reg_p1[i*REG_AW +: REG_AW] != '0) && !conflict[i];
         bus.result[i*DATA_W +: DATA_W] = mem_to_reg_p1[i]
            ? load_extract(read_data_p1[i*DATA_W +: DATA_W], ld_size_p1[i*2 +: 2],
                           ld_unsigned_p1[i], byte_off_p1[i*2 +: 2])
            : alu_result_p1[i*DATA_W +: DATA_W];
      end
   end

   assign bus.wb_valid  = vld_p1;
   assign bus.write_reg = write_reg_p1;

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed, table-driven bench for writeback_stage with
// LANES=2 (lane 0 alone covers the single-lane cases). Multi-cycle reset,
// stall/flush and retire counter sequences are written out by hand.
module tb_writeback_stage;
   localparam int LANES  = 2;
   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   logic clk = 1'b0;
   logic reset, stall, flush;
`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_cnt;
`endif

   writeback_stage_if #(.LANES(LANES), .DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

   writeback_stage #(.LANES(LANES), .DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .flush(flush),
      .bus(bus)
`ifdef WB_RETIRE_CNT_EN
      ,
      .retire_cnt(retire_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  valid, rw, m2r, uns;
      logic [9:0]  wreg;
      logic [63:0] alu, rdata;
      logic [3:0]  size, off;
      logic [1:0]  e_vld, e_rw;
      logic [63:0] e_res;
   } vec_t;

   vec_t vecs [14];
   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.in_valid       = v.valid;
      bus.in_reg_write   = v.rw;
      bus.in_mem_to_reg  = v.m2r;
      bus.in_ld_unsigned = v.uns;
      bus.in_write_reg   = v.wreg;
      bus.in_alu_result  = v.alu;
      bus.in_read_data   = v.rdata;
      bus.in_ld_size     = v.size;
      bus.in_byte_off    = v.off;
   endtask

   task automatic drive_random();
      bus.in_valid       = 2'($urandom);
      bus.in_reg_write   = 2'($urandom);
      bus.in_mem_to_reg  = 2'($urandom);
      bus.in_ld_unsigned = 2'($urandom);
      bus.in_write_reg   = 10'($urandom);
      bus.in_alu_result  = {$urandom, $urandom};
      bus.in_read_data   = {$urandom, $urandom};
      bus.in_ld_size     = 4'($urandom);
      bus.in_byte_off    = 4'($urandom);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string name, input logic [1:0] e_vld, input logic [1:0] e_rw,
                          input logic [63:0] e_res);
      chk({name, ".wb_valid"}, 64'(bus.wb_valid), 64'(e_vld));
      chk({name, ".reg_write"}, 64'(bus.reg_write), 64'(e_rw));
      chk({name, ".result"}, bus.result, e_res);
   endtask

   initial begin
      vec_t v;
      // lb signed, off 3
      vecs[0]  = '{2'b01, 2'b01, 2'b01, 2'b00, {5'd0, 5'd3}, 64'h0, {32'h0, 32'h80FF7F01},
                   4'b0000, 4'b0011, 2'b01, 2'b01, {32'h0, 32'hFFFFFF80}};
      // lbu, off 3
      vecs[1]  = '{2'b01, 2'b01, 2'b01, 2'b01, {5'd0, 5'd3}, 64'h0, {32'h0, 32'h80FF7F01},
                   4'b0000, 4'b0011, 2'b01, 2'b01, {32'h0, 32'h00000080}};
      // lh signed, off 2
      vecs[2]  = '{2'b01, 2'b01, 2'b01, 2'b00, {5'd0, 5'd3}, 64'h0, {32'h0, 32'h80FF7F01},
                   4'b0001, 4'b0010, 2'b01, 2'b01, {32'h0, 32'hFFFF80FF}};
      // ALU write to $0 is suppressed but result still shown
      vecs[3]  = '{2'b01, 2'b01, 2'b00, 2'b00, {5'd0, 5'd0}, {32'h0, 32'h1234}, 64'h0,
                   4'b0000, 4'b0000, 2'b01, 2'b00, {32'h0, 32'h1234}};
      // both lanes write r5: youngest wins
      vecs[4]  = '{2'b11, 2'b11, 2'b00, 2'b00, {5'd5, 5'd5}, {32'h22, 32'h11}, 64'h0,
                   4'b0000, 4'b0000, 2'b11, 2'b10, {32'h22, 32'h11}};
      // different registers: both write
      vecs[5]  = '{2'b11, 2'b11, 2'b00, 2'b00, {5'd6, 5'd5}, {32'h22, 32'h11}, 64'h0,
                   4'b0000, 4'b0000, 2'b11, 2'b11, {32'h22, 32'h11}};
      // lane0 lh signed off0, lane1 lbu off1
      vecs[6]  = '{2'b11, 2'b11, 2'b11, 2'b10, {5'd2, 5'd1}, 64'h0, {32'h80FF7F01, 32'h80FF7F01},
                   4'b0001, 4'b0100, 2'b11, 2'b11, {32'h0000007F, 32'h00007F01}};
      // word and size 11: data unchanged regardless of offset
      vecs[7]  = '{2'b11, 2'b11, 2'b11, 2'b00, {5'd4, 5'd3}, {32'hAAAA, 32'hBBBB},
                   {32'h12345678, 32'hDEADBEEF}, 4'b1110, 4'b1011, 2'b11, 2'b11,
                   {32'h12345678, 32'hDEADBEEF}};
      // lane0 lhu off3 (off[0] ignored), lane1 lb signed off2
      vecs[8]  = '{2'b11, 2'b11, 2'b11, 2'b01, {5'd2, 5'd1}, 64'h0, {32'h80FF7F01, 32'h80FF7F01},
                   4'b0001, 4'b1011, 2'b11, 2'b11, {32'hFFFFFFFF, 32'h000080FF}};
      // invalid lanes never write
      vecs[9]  = '{2'b00, 2'b11, 2'b00, 2'b00, {5'd8, 5'd9}, {32'h5, 32'h6}, 64'h0,
                   4'b0000, 4'b0000, 2'b00, 2'b00, {32'h5, 32'h6}};
      // younger lane invalid: no conflict
      vecs[10] = '{2'b01, 2'b11, 2'b00, 2'b00, {5'd7, 5'd7}, {32'h2, 32'h1}, 64'h0,
                   4'b0000, 4'b0000, 2'b01, 2'b01, {32'h2, 32'h1}};
      // younger lane not writing: no conflict
      vecs[11] = '{2'b11, 2'b01, 2'b00, 2'b00, {5'd7, 5'd7}, {32'h2, 32'h1}, 64'h0,
                   4'b0000, 4'b0000, 2'b11, 2'b01, {32'h2, 32'h1}};
      // both lanes target $0
      vecs[12] = '{2'b11, 2'b11, 2'b00, 2'b00, {5'd0, 5'd0}, {32'h2, 32'h1}, 64'h0,
                   4'b0000, 4'b0000, 2'b11, 2'b00, {32'h2, 32'h1}};
      // mux: lane0 load, lane1 ALU with nonzero memory data
      vecs[13] = '{2'b11, 2'b11, 2'b01, 2'b00, {5'd11, 5'd10}, {32'h77, 32'h99},
                   {32'hCAFEF00D, 32'h000000FE}, 4'b0000, 4'b0000, 2'b11, 2'b11,
                   {32'h77, 32'hFFFFFFFE}};

      // Reset with random inputs
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      drive_random();
      for (int c = 0; c < 2; c++) begin
         step();
         chk($sformatf("reset%0d", c), {bus.wb_valid, bus.reg_write, bus.write_reg, bus.result},
             64'h0);
         chk_out($sformatf("reset%0d", c), 2'b00, 2'b00, 64'h0);
         drive_random();
      end
      reset = 1'b0;
      #3;
      chk_out("post_reset", 2'b00, 2'b00, 64'h0);
      chk("post_reset.write_reg", 64'(bus.write_reg), 64'h0);
      chk("in_ready", 64'(bus.in_ready), 64'h1);

      // Table-driven vectors
      for (int k = 0; k < 14; k++) begin
         drive(vecs[k]);
         step();
         chk_out($sformatf("vec%0d", k), vecs[k].e_vld, vecs[k].e_rw, vecs[k].e_res);
         chk($sformatf("vec%0d.write_reg", k), 64'(bus.write_reg), 64'(vecs[k].wreg));
      end

      // Stall holds for 3 cycles while inputs change
      v = vecs[5];
      drive(v);
      step();
      chk_out("pre_stall", 2'b11, 2'b11, {32'h22, 32'h11});
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         drive(vecs[c]);
         #1;
         chk($sformatf("stall%0d.in_ready", c), 64'(bus.in_ready), 64'h0);
         step();
         chk_out($sformatf("stall%0d", c), 2'b11, 2'b11, {32'h22, 32'h11});
         chk($sformatf("stall%0d.write_reg", c), 64'(bus.write_reg), {54'h0, 5'd6, 5'd5});
      end
      stall = 1'b0;
      drive(vecs[0]);
      step();
      chk_out("unstall", 2'b01, 2'b01, {32'h0, 32'hFFFFFF80});
      chk("unstall.in_ready", 64'(bus.in_ready), 64'h1);

      // Flush beats stall
      stall = 1'b1; flush = 1'b1;
      drive(vecs[5]);
      step();
      chk("stall_flush.wb_valid", 64'(bus.wb_valid), 64'h0);
      chk("stall_flush.reg_write", 64'(bus.reg_write), 64'h0);
      stall = 1'b0; flush = 1'b0;
      step();
      chk_out("after_flush", 2'b11, 2'b11, {32'h22, 32'h11});
      flush = 1'b1;
      step();
      chk("flush.wb_valid", 64'(bus.wb_valid), 64'h0);
      flush = 1'b0;

`ifdef WB_RETIRE_CNT_EN
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("cnt.reset", 64'(retire_cnt), 64'h0);
      drive(vecs[5]);             // two valid lanes
      step();
      chk("cnt.a", 64'(retire_cnt), 64'h0);
      drive(vecs[0]);             // one valid lane
      step();
      chk("cnt.b", 64'(retire_cnt), 64'h2);
      stall = 1'b1;
      step();
      chk("cnt.stall", 64'(retire_cnt), 64'h2);
      stall = 1'b0; flush = 1'b1;
      step();
      chk("cnt.flush", 64'(retire_cnt), 64'h2);
      flush = 1'b0;
      drive(vecs[5]);
      step();
      chk("cnt.e", 64'(retire_cnt), 64'h2);
      drive(vecs[9]);             // no valid lanes
      step();
      chk("cnt.f", 64'(retire_cnt), 64'h4);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
